// File: rtl/aes_shift_pkg.sv
// Shared helpers for the ShiftRows stream stage: width helpers and the row rotator.
package aes_shift_pkg;

  // Rotator is written against the largest supported row; NB <= NB_MAX and BW <= BW_MAX.
  localparam int unsigned NB_MAX    = 16;
  localparam int unsigned BW_MAX    = 16;
  localparam int unsigned ROW_MAX_W = NB_MAX * BW_MAX;
  localparam int unsigned IDX_W     = $clog2(ROW_MAX_W);

  // Index width for a range of n values, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Source column feeding output column j for a rotation by k (k < nb).
  function automatic int unsigned src_col(input int unsigned j, input int unsigned k,
                                          input int unsigned nb, input logic inv);
    int unsigned s;
    s = inv ? (j + nb - k) : (j + k);
    if (s >= nb) s = s - nb;
    return s;
  endfunction

  // Cyclic byte rotation of one row: forward out[j]=in[j+k], inverse out[j]=in[j-k].
  function automatic logic [ROW_MAX_W-1:0] rot_row(input logic [ROW_MAX_W-1:0] data,
                                                   input int unsigned k,
                                                   input int unsigned nb,
                                                   input int unsigned bw,
                                                   input logic inv);
    logic [ROW_MAX_W-1:0] res;
    int unsigned s;
    res = '0;
    for (int unsigned j = 0; j < NB_MAX; j++) begin
      if (j < nb) begin
        s = src_col(j, k, nb, inv);
        for (int unsigned b = 0; b < BW_MAX; b++) begin
          if (b < bw) res[IDX_W'(j * bw + b)] = data[IDX_W'(s * bw + b)];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_sync_fifo.sv
// Small synchronous FIFO with wrapping pointers; storage is cleared on reset/flush.
module mod_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointer, count and storage update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[PW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mod_enc_shiftrows_stream.sv
// Streaming ShiftRows / InvShiftRows stage: rotates each row by its index and queues the result.
module mod_enc_shiftrows_stream
  import aes_shift_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned NROWS = 4,
  parameter int unsigned BW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NB*BW-1:0]          in_data,
  input  logic                      in_inv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NB*BW-1:0]          out_data,
  output logic [idx_w(NROWS)-1:0]   out_row,
  output logic                      out_last,
  output logic                      out_inv
);

  localparam int unsigned ROW_W = NB * BW;
  localparam int unsigned RW    = idx_w(NROWS);
  localparam int unsigned EW    = ROW_W + RW + 2;

  logic [RW-1:0]    row_q;
  logic             mode_q;
  logic             clr;
  logic             accept;
  logic             row_last;
  logic             eff_inv;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ROW_W-1:0] rot_data;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;

  // resetn is an active-high synchronous clear; flush has the same effect.
  assign clr      = resetn || flush;
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready && !clr;
  assign row_last = (row_q == RW'(NROWS - 1));

  // Row 0 takes the live mode bit; later rows reuse the mode latched on row 0.
  assign eff_inv  = (row_q == '0) ? in_inv : mode_q;

  // Rotation sits at the FIFO write port, so outputs only ever come from storage.
  assign rot_data = ROW_W'(rot_row(ROW_MAX_W'(in_data), 32'(row_q) % NB, NB, BW, eff_inv));
  assign wr_entry = {rot_data, row_q, row_last, eff_inv};

  // Row counter and block-mode register.
  always_ff @(posedge clk) begin
    if (clr) begin
      row_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      if (row_q == '0) mode_q <= in_inv;
      row_q <= row_last ? '0 : row_q + RW'(1);
    end
  end

  mod_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (resetn),
    .flush (flush),
    .push  (accept),
    .pop   (out_ready),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rd_entry[EW-1 -: ROW_W];
  assign out_row   = rd_entry[RW+1:2];
  assign out_last  = rd_entry[1];
  assign out_inv   = rd_entry[0];

endmodule

// File: tb/tb_mod_enc_shiftrows_stream.sv
// Bench for mod_enc_shiftrows_stream: directed blocks, backpressure, reset/flush, random traffic.
`timescale 1ns/1ps
module tb_mod_enc_shiftrows_stream;

  localparam int unsigned NB    = 4;
  localparam int unsigned NROWS = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned RW    = 2;
  localparam int unsigned W     = NB * BW;

  logic          clk = 1'b0;
  logic          resetn, flush, in_valid, in_ready, in_inv;
  logic          out_valid, out_ready, out_last, out_inv;
  logic [W-1:0]  in_data, out_data;
  logic [RW-1:0] out_row;

  always #5 clk = ~clk;

  mod_enc_shiftrows_stream #(.NB(NB), .NROWS(NROWS), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .out_inv(out_inv)
  );

  typedef struct {
    logic [W-1:0] data;
    int unsigned  row;
    logic         last;
    logic         inv;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        log_q[$];
  int unsigned m_row    = 0;
  logic        m_mode   = 1'b0;
  bit          model_ok = 1'b0;
  bit          just_clr = 1'b0;
  int          errors   = 0;
  int          checks   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference rotation straight from the byte-index rule.
  function automatic logic [W-1:0] model_rot(input logic [W-1:0] d, input int k, input logic inv);
    logic [BW-1:0] b_in [NB];
    logic [W-1:0]  r;
    for (int j = 0; j < NB; j++) b_in[j] = d[j*BW +: BW];
    for (int j = 0; j < NB; j++)
      r[j*BW +: BW] = inv ? b_in[(j - k + NB) % NB] : b_in[(j + k) % NB];
    return r;
  endfunction

  // Compare DUT against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    ent_t e;
    bit   acc;
    bit   pop;
    if (model_ok) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      if (just_clr) begin
        chk("clr_data", 64'(out_data), 64'(0));
        chk("clr_row", 64'(out_row), 64'(0));
        chk("clr_last", 64'(out_last), 64'(0));
        chk("clr_inv", 64'(out_inv), 64'(0));
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].data));
        chk("out_row", 64'(out_row), 64'(exp_q[0].row));
        chk("out_last", 64'(out_last), 64'(exp_q[0].last));
        chk("out_inv", 64'(out_inv), 64'(exp_q[0].inv));
      end
    end
    if (resetn === 1'b1 || flush === 1'b1) begin
      exp_q.delete();
      m_row    = 0;
      m_mode   = 1'b0;
      model_ok = 1'b1;
      just_clr = 1'b1;
    end else if (model_ok) begin
      just_clr = 1'b0;
      acc = (in_valid === 1'b1) && (exp_q.size() < DEPTH);
      pop = (out_ready === 1'b1) && (exp_q.size() != 0);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        e.data = out_data; e.row = 32'(out_row); e.last = out_last; e.inv = out_inv;
        log_q.push_back(e);
      end
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        e.inv  = (m_row == 0) ? in_inv : m_mode;
        if (m_row == 0) m_mode = in_inv;
        e.data = model_rot(in_data, int'(m_row % NB), e.inv);
        e.row  = m_row;
        e.last = (m_row == NROWS - 1);
        exp_q.push_back(e);
        m_row  = (m_row + 1) % NROWS;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [W-1:0] d, input logic inv);
    int budget = 50;
    bit taken  = 1'b0;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    while (!taken && budget > 0) begin
      taken = in_ready && !resetn && !flush;
      cyc();
      budget--;
    end
    in_valid = 1'b0;
    if (!taken) begin
      checks++; errors++;
      $display("FAIL send_row_timeout: got no accept want accept of 0x%0h", d);
    end
  endtask

  task automatic chk_log(input int idx, input logic [W-1:0] d, input int unsigned row,
                         input logic last, input logic inv);
    if (idx >= log_q.size()) begin
      checks++; errors++;
      $display("FAIL log_missing: got %0d entries want entry %0d", log_q.size(), idx);
    end else begin
      chk($sformatf("log%0d_data", idx), 64'(log_q[idx].data), 64'(d));
      chk($sformatf("log%0d_row", idx), 64'(log_q[idx].row), 64'(row));
      chk($sformatf("log%0d_last", idx), 64'(log_q[idx].last), 64'(last));
      chk($sformatf("log%0d_inv", idx), 64'(log_q[idx].inv), 64'(inv));
    end
  endtask

  task automatic do_flush();
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    log_q.delete();
  endtask

  initial begin
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    log_q.delete();

    // Forward block
    out_ready = 1'b1;
    send_row(32'h00010203, 1'b0);
    send_row(32'h10111213, 1'b1);
    send_row(32'h20212223, 1'b1);
    send_row(32'h30313233, 1'b1);
    repeat (3) cyc();
    chk_log(0, 32'h00010203, 0, 1'b0, 1'b0);
    chk_log(1, 32'h13101112, 1, 1'b0, 1'b0);
    chk_log(2, 32'h22232021, 2, 1'b0, 1'b0);
    chk_log(3, 32'h31323330, 3, 1'b1, 1'b0);
    log_q.delete();

    // Inverse block, in_inv toggling on rows 1..3
    send_row(32'h00010203, 1'b1);
    send_row(32'h10111213, 1'b0);
    send_row(32'h20212223, 1'b1);
    send_row(32'h30313233, 1'b0);
    repeat (3) cyc();
    chk_log(0, 32'h00010203, 0, 1'b0, 1'b1);
    chk_log(1, 32'h11121310, 1, 1'b0, 1'b1);
    chk_log(2, 32'h22232021, 2, 1'b0, 1'b1);
    chk_log(3, 32'h33303132, 3, 1'b1, 1'b1);

    // Backpressure with a two-entry FIFO
    do_flush();
    out_ready = 1'b0;
    send_row(32'h00010203, 1'b0);
    send_row(32'h10111213, 1'b0);
    in_valid = 1'b1; in_data = 32'h20212223; in_inv = 1'b0;
    repeat (3) cyc();
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    send_row(32'h20212223, 1'b0);
    repeat (4) cyc();
    chk_log(0, 32'h00010203, 0, 1'b0, 1'b0);
    chk_log(1, 32'h13101112, 1, 1'b0, 1'b0);
    chk_log(2, 32'h22232021, 2, 1'b0, 1'b0);

    // Sustained push+pop at count=1
    do_flush();
    out_ready = 1'b0;
    send_row(32'h00010203, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_row(32'h00010203, 1'b0);
    repeat (3) cyc();
    chk("pp_log_size", 64'(log_q.size()), 64'(9));
    for (int i = 0; i < 9; i++)
      if (i < log_q.size()) chk($sformatf("pp_row%0d", i), 64'(log_q[i].row), 64'(i % 4));

    // Reset mid-block
    do_flush();
    send_row(32'h00010203, 1'b0);
    send_row(32'h10111213, 1'b0);
    resetn = 1'b1;
    cyc();
    resetn = 1'b0;
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    log_q.delete();
    send_row(32'h10111213, 1'b0);
    repeat (2) cyc();
    chk_log(0, 32'h10111213, 0, 1'b0, 1'b0);

    // Flush while full with a row on the input
    do_flush();
    out_ready = 1'b0;
    send_row(32'h00010203, 1'b1);
    send_row(32'h10111213, 1'b1);
    in_valid = 1'b1; in_data = 32'hdeadbeef; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    log_q.delete();
    out_ready = 1'b1;
    send_row(32'h10111213, 1'b0);
    send_row(32'h10111213, 1'b1);
    repeat (3) cyc();
    chk_log(0, 32'h10111213, 0, 1'b0, 1'b0);
    chk_log(1, 32'h13101112, 1, 1'b0, 1'b0);

    // Random traffic with occasional flush/reset
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom());
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      resetn    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; resetn = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
